// File: rtl/ulx3s_pll_supervisor.sv
// ulx3s_pll_supervisor: ECP5 EHXPLLL lock supervisor and
// dynamic phase-step sequencer on the 25 MHz reference clock.

module ulx3s_pll_supervisor #(
   parameter int unsigned RST_CYCLES   = 16,
   parameter int unsigned LOCK_TIMEOUT = 65535,
   parameter int unsigned LOCK_STABLE  = 1024,
   parameter int unsigned PULSE_W      = 4,
   parameter int unsigned GAP          = 8
) (
   input  logic       clkin,
   input  logic       rst_n,
   input  logic       pll_locked,
   output logic       pll_rst,
   output logic       sys_rst_n,
   output logic [1:0] phasesel,
   output logic       phasedir,
   output logic       phasestep,
   output logic       phaseloadreg,
   input  logic       step_valid,
   output logic       step_ready,
   input  logic [1:0] step_sel,
   input  logic       step_dir,
   input  logic [3:0] step_n,
   output logic       step_done,
   output logic       step_err,
   output logic [7:0] retries,
   output logic       locked_ok
);

   typedef enum logic [2:0] {
      S_RESET_PLL,
      S_WAIT_LOCK,
      S_STABLE,
      S_RUN,
      S_STEP_SETUP,
      S_STEP_PULSE,
      S_STEP_GAP,
      S_STEP_LOAD
   } state_t;

   localparam logic [19:0] C_RST = 20'(RST_CYCLES - 1);
   localparam logic [19:0] C_TMO = 20'(LOCK_TIMEOUT - 1);
   localparam logic [19:0] C_STB = 20'(LOCK_STABLE - 1);
   localparam logic [19:0] C_PW  = 20'(PULSE_W - 1);
   localparam logic [19:0] C_GAP = 20'(GAP - 1);
   localparam logic [19:0] C_LD  = 20'(PULSE_W + GAP - 1);
   localparam logic [19:0] C_PWN = 20'(PULSE_W);

   state_t      r_state, w_state_nx;
   logic [19:0] r_cnt, w_cnt_nx;
   logic        r_sync1, r_sync2;
   logic        w_lock;
   logic [3:0]  r_rem, w_rem_nx;
   logic [1:0]  r_sel, w_sel_nx;
   logic        r_dir, w_dir_nx;
   logic [7:0]  r_retries, w_retries_nx;
   logic        w_done_nx, w_err_nx;
   logic        w_up, w_up_nx;
   logic        r_pll_rst, r_sys_rst_n, r_phasestep, r_phaseload;
   logic        r_ready, r_done, r_err, r_locked_ok;

   assign w_lock  = r_sync2;
   assign w_up    = (r_state inside {S_RUN, S_STEP_SETUP,
                     S_STEP_PULSE, S_STEP_GAP, S_STEP_LOAD});
   assign w_up_nx = (w_state_nx inside {S_RUN, S_STEP_SETUP,
                     S_STEP_PULSE, S_STEP_GAP, S_STEP_LOAD});

   // two-flop synchroniser for the asynchronous LOCK input
   always_ff @(posedge clkin or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= pll_locked;
         r_sync2 <= r_sync1;
      end
   end

   // state, counter and latched request registers
   always_ff @(posedge clkin or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_RESET_PLL;
         r_cnt     <= '0;
         r_rem     <= '0;
         r_sel     <= 2'd0;
         r_dir     <= 1'b1;
         r_retries <= '0;
      end else begin
         r_state   <= w_state_nx;
         r_cnt     <= w_cnt_nx;
         r_rem     <= w_rem_nx;
         r_sel     <= w_sel_nx;
         r_dir     <= w_dir_nx;
         r_retries <= w_retries_nx;
      end
   end

   // next-state logic; lock loss while up overrides everything
   always_comb begin
      w_state_nx   = r_state;
      w_cnt_nx     = r_cnt + 20'd1;
      w_rem_nx     = r_rem;
      w_sel_nx     = r_sel;
      w_dir_nx     = r_dir;
      w_retries_nx = r_retries;
      w_done_nx    = 1'b0;
      w_err_nx     = 1'b0;
      unique case (r_state)
         S_RESET_PLL: begin
            if (r_cnt == C_RST) begin
               w_state_nx = S_WAIT_LOCK;
               w_cnt_nx   = '0;
            end
         end
         S_WAIT_LOCK: begin
            if (w_lock) begin
               w_state_nx = S_STABLE;
               w_cnt_nx   = '0;
            end else if (r_cnt == C_TMO) begin
               w_state_nx = S_RESET_PLL;
               w_cnt_nx   = '0;
               if (r_retries != 8'hFF)
                  w_retries_nx = r_retries + 8'd1;
            end
         end
         S_STABLE: begin
            if (!w_lock) begin
               w_state_nx = S_WAIT_LOCK;
               w_cnt_nx   = '0;
            end else if (r_cnt == C_STB) begin
               w_state_nx = S_RUN;
               w_cnt_nx   = '0;
            end
         end
         S_RUN: begin
            w_cnt_nx = '0;
            if (step_valid && r_ready) begin
               w_sel_nx = step_sel;
               w_dir_nx = step_dir;
               if (step_n == 4'd0) begin
                  w_done_nx = 1'b1;
               end else begin
                  w_state_nx = S_STEP_SETUP;
                  w_rem_nx   = step_n;
               end
            end
         end
         S_STEP_SETUP: begin
            if (r_cnt == 20'd1) begin
               w_state_nx = S_STEP_PULSE;
               w_cnt_nx   = '0;
            end
         end
         S_STEP_PULSE: begin
            if (r_cnt == C_PW) begin
               w_state_nx = S_STEP_GAP;
               w_cnt_nx   = '0;
            end
         end
         S_STEP_GAP: begin
            if (r_cnt == C_GAP) begin
               w_cnt_nx   = '0;
               w_rem_nx   = r_rem - 4'd1;
               w_state_nx = (r_rem == 4'd1) ? S_STEP_LOAD
                                             : S_STEP_PULSE;
            end
         end
         S_STEP_LOAD: begin
            if (r_cnt == C_LD) begin
               w_state_nx = S_RUN;
               w_cnt_nx   = '0;
               w_done_nx  = 1'b1;
            end
         end
         default: begin
            w_state_nx = S_RESET_PLL;
            w_cnt_nx   = '0;
         end
      endcase
      if (w_up && !w_lock) begin
         w_state_nx = S_RESET_PLL;
         w_cnt_nx   = '0;
         w_rem_nx   = r_rem;
         w_sel_nx   = r_sel;
         w_dir_nx   = r_dir;
         w_done_nx  = (r_state != S_RUN);
         w_err_nx   = (r_state != S_RUN);
      end
   end

   // registered outputs derived from the upcoming state
   always_ff @(posedge clkin or negedge rst_n) begin
      if (!rst_n) begin
         r_pll_rst   <= 1'b1;
         r_sys_rst_n <= 1'b0;
         r_phasestep <= 1'b1;
         r_phaseload <= 1'b1;
         r_ready     <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
         r_locked_ok <= 1'b0;
      end else begin
         r_pll_rst   <= (w_state_nx == S_RESET_PLL);
         r_sys_rst_n <= w_up_nx;
         r_phasestep <= (w_state_nx != S_STEP_PULSE);
         r_phaseload <= !((w_state_nx == S_STEP_LOAD)
                          && (w_cnt_nx < C_PWN));
         r_ready     <= (w_state_nx == S_RUN);
         r_done      <= w_done_nx;
         r_err       <= w_err_nx;
         r_locked_ok <= w_up_nx;
      end
   end

   assign pll_rst      = r_pll_rst;
   assign sys_rst_n    = r_sys_rst_n;
   assign phasesel     = r_sel;
   assign phasedir     = r_dir;
   assign phasestep    = r_phasestep;
   assign phaseloadreg = r_phaseload;
   assign step_ready   = r_ready;
   assign step_done    = r_done;
   assign step_err     = r_err;
   assign retries      = r_retries;
   assign locked_ok    = r_locked_ok;

endmodule
